// File: rtl/imem_loader.sv
// imem_loader: byte-stream program loader that fills instruction memory and
// holds the processor in reset until the whole image has been written.
// Latency: 4th byte of a word accepted at edge t -> mem_we high t..t+1;
//          after the last word, done/cpu_rst_n rise at edge t+2.
// Backpressure: in_ready drops in IDLE, WRITE, DONE and ERR; bytes are never
//               consumed without in_valid&&in_ready, and stalls may last forever.
//
// Ports:
//   CLK        rising-edge clock
//   RST        asynchronous active-low reset
//   start      single-cycle pulse; starts a load from IDLE, DONE or ERR
//   in_data    stream byte: 16-bit big-endian word count, then big-endian words
//   in_valid   in_data valid
//   in_ready   byte accepted this cycle when in_valid is also high
//   mem_we     one-cycle write strobe per assembled word
//   mem_addr   word address of the write (starts at 0, increments by 1)
//   mem_wdata  assembled 32-bit instruction word
//   cpu_rst_n  processor reset, released only after a complete load
//   done       high while the loader sits in DONE
//   error      high while the loader sits in ERR (word count too large)

module imem_loader #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  start,
   input  logic [7:0]            in_data,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   output logic                  cpu_rst_n,
   output logic                  done,
   output logic                  error
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LEN_HI,
      S_LEN_LO,
      S_DATA,
      S_WRITE,
      S_DONE,
      S_ERR
   } state_t;

   // Memory depth, held in 17 bits so that a 16-bit count can be compared
   // against it even when the memory is 2**16 words deep.
   localparam logic [16:0] DEPTH = 17'd1 << ADDR_WIDTH;

   state_t                state;
   logic [15:0]           count;
   logic [1:0]            byte_idx;
   // Only the first three bytes of a word need storing; the fourth goes
   // straight from in_data into mem_wdata.
   logic [DATA_WIDTH-9:0] shreg;

   logic                  xfer;
   logic [15:0]           len_full;
   logic                  last_word;

   // in_ready is a pure decode of the current state.
   always_comb begin
      in_ready = 1'b0;
      case (state)
         S_LEN_HI, S_LEN_LO, S_DATA: in_ready = 1'b1;
         default:                    in_ready = 1'b0;
      endcase
   end

   assign xfer     = in_valid && in_ready;
   // Full count as it will be once the low byte lands, so the LEN_LO
   // decision can be made in the same cycle the byte is accepted.
   assign len_full = {count[15:8], in_data};
   // mem_addr holds the address being written; it is the last word when
   // address+1 equals the requested count.
   assign last_word = ((17'(mem_addr) + 17'd1) == {1'b0, count});

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state     <= S_IDLE;
         count     <= '0;
         byte_idx  <= '0;
         shreg     <= '0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         cpu_rst_n <= 1'b0;
         done      <= 1'b0;
         error     <= 1'b0;
      end else begin
         // Status outputs are re-derived every cycle; they are only held
         // high by the DONE/ERR branches below.
         mem_we    <= 1'b0;
         cpu_rst_n <= 1'b0;
         done      <= 1'b0;
         error     <= 1'b0;

         case (state)
            S_IDLE: begin
               if (start) begin
                  state    <= S_LEN_HI;
                  mem_addr <= '0;
               end
            end

            S_LEN_HI: begin
               if (xfer) begin
                  count[15:8] <= in_data;
                  state       <= S_LEN_LO;
               end
            end

            S_LEN_LO: begin
               if (xfer) begin
                  count[7:0] <= in_data;
                  if (len_full == 16'd0) begin
                     state <= S_DONE;
                  end else if ({1'b0, len_full} > DEPTH) begin
                     state <= S_ERR;
                  end else begin
                     state    <= S_DATA;
                     byte_idx <= 2'd0;
                  end
               end
            end

            S_DATA: begin
               if (xfer) begin
                  shreg <= {shreg[DATA_WIDTH-17:0], in_data};
                  if (byte_idx == 2'd3) begin
                     // Fourth byte: the word is complete, present it to the
                     // memory during the WRITE cycle.
                     mem_we    <= 1'b1;
                     mem_wdata <= {shreg, in_data};
                     state     <= S_WRITE;
                  end else begin
                     byte_idx <= byte_idx + 2'd1;
                  end
               end
            end

            S_WRITE: begin
               if (last_word) begin
                  // Address is left on the final word, so a full-depth
                  // image ends at the all-ones address without wrapping.
                  state <= S_DONE;
               end else begin
                  mem_addr <= mem_addr + 1'b1;
                  byte_idx <= 2'd0;
                  state    <= S_DATA;
               end
            end

            S_DONE: begin
               if (start) begin
                  // Re-assert processor reset immediately on reload.
                  state    <= S_LEN_HI;
                  mem_addr <= '0;
               end else begin
                  done      <= 1'b1;
                  cpu_rst_n <= 1'b1;
               end
            end

            S_ERR: begin
               if (start) begin
                  state    <= S_LEN_HI;
                  mem_addr <= '0;
               end else begin
                  error <= 1'b1;
               end
            end

            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: two instances (8-bit and 2-bit address)
// share the same stimulus; writes from each are logged by negedge monitors.
module tb_imem_loader;

   logic        CLK;
   logic        RST;
   logic        start;
   logic [7:0]  in_data;
   logic        in_valid;

   logic        rdy8, we8, crst8, done8, err8;
   logic [7:0]  addr8;
   logic [31:0] wdata8;

   logic        rdy2, we2, crst2, done2, err2;
   logic [1:0]  addr2;
   logic [31:0] wdata2;

   int vectors;
   int miscompares;

   typedef struct packed {
      logic [7:0]  addr;
      logic [31:0] data;
      logic        rdy;
   } wr_t;

   wr_t q8[$];
   wr_t q2[$];

   imem_loader #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) dut8 (
      .CLK(CLK), .RST(RST), .start(start), .in_data(in_data),
      .in_valid(in_valid), .in_ready(rdy8), .mem_we(we8), .mem_addr(addr8),
      .mem_wdata(wdata8), .cpu_rst_n(crst8), .done(done8), .error(err8)
   );

   imem_loader #(.ADDR_WIDTH(2), .DATA_WIDTH(32)) dut2 (
      .CLK(CLK), .RST(RST), .start(start), .in_data(in_data),
      .in_valid(in_valid), .in_ready(rdy2), .mem_we(we2), .mem_addr(addr2),
      .mem_wdata(wdata2), .cpu_rst_n(crst2), .done(done2), .error(err2)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   always @(negedge CLK) begin
      if (we8) q8.push_back(wr_t'({addr8, wdata8, rdy8}));
      if (we2) q2.push_back(wr_t'({6'd0, addr2, wdata2, rdy2}));
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge CLK);
      @(negedge CLK);
   endtask

   task automatic pulse_start;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // Offer one byte, wait (bounded) for in_ready, then let it transfer.
   // in_valid is left high; callers drop it when they want a stall.
   task automatic send(input logic [7:0] b);
      int n;
      in_data  = b;
      in_valid = 1'b1;
      n = 0;
      while (!rdy8 && n < 20) begin
         tick();
         n++;
      end
      check("hs_timeout", 64'(n < 20), 64'd1);
      tick();
   endtask

   task automatic check_wr(input string tag, input wr_t q[$], input int idx,
                           input logic [7:0] a, input logic [31:0] d);
      if (q.size() > idx) begin
         check({tag, "_addr"}, 64'(q[idx].addr), 64'(a));
         check({tag, "_data"}, 64'(q[idx].data), 64'(d));
         check({tag, "_rdy"},  64'(q[idx].rdy),  64'd0);
      end else begin
         check({tag, "_missing"}, 64'(q.size()), 64'(idx + 1));
      end
   endtask

   logic [7:0] img [0:9];

   initial begin
      vectors     = 0;
      miscompares = 0;
      RST      = 1'b0;
      start    = 1'b0;
      in_data  = 8'h00;
      in_valid = 1'b0;
      img = '{8'h00, 8'h02, 8'h20, 8'h01, 8'h00, 8'h05, 8'hAC, 8'h01, 8'h00, 8'h00};

      // Reset values
      #12;
      check("rst_rdy",   64'(rdy8),   64'd0);
      check("rst_we",    64'(we8),    64'd0);
      check("rst_addr",  64'(addr8),  64'd0);
      check("rst_wdata", 64'(wdata8), 64'd0);
      check("rst_crst",  64'(crst8),  64'd0);
      check("rst_done",  64'(done8),  64'd0);
      check("rst_err",   64'(err8),   64'd0);
      @(negedge CLK);
      RST = 1'b1;
      tick();
      check("idle_rdy", 64'(rdy8), 64'd0);

      // 1: two-word image, continuous valid
      pulse_start();
      q8.delete(); q2.delete();
      for (int i = 0; i < 10; i++) send(img[i]);
      in_valid = 1'b0;
      check("t1_we_last", 64'(we8),   64'd1);
      check("t1_done_t0", 64'(done8), 64'd0);
      tick();
      check("t1_done_t1", 64'(done8), 64'd0);
      check("t1_crst_t1", 64'(crst8), 64'd0);
      tick();
      check("t1_done_t2", 64'(done8), 64'd1);
      check("t1_crst_t2", 64'(crst8), 64'd1);
      check("t1_nwr", 64'(q8.size()), 64'd2);
      check_wr("t1_w0", q8, 0, 8'd0, 32'h20010005);
      check_wr("t1_w1", q8, 1, 8'd1, 32'hAC010000);

      // 2: same image, in_valid toggling
      pulse_start();
      check("t2_done_fall", 64'(done8), 64'd0);
      q8.delete(); q2.delete();
      for (int i = 0; i < 10; i++) begin
         send(img[i]);
         in_valid = 1'b0;
         if (i != 5 && i != 9) check("t2_stall_rdy", 64'(rdy8), 64'd1);
         tick();
      end
      tick();
      check("t2_done", 64'(done8), 64'd1);
      check("t2_nwr", 64'(q8.size()), 64'd2);
      check_wr("t2_w0", q8, 0, 8'd0, 32'h20010005);
      check_wr("t2_w1", q8, 1, 8'd1, 32'hAC010000);

      // 3: oversize header -> ERR, then empty image -> DONE
      pulse_start();
      q8.delete(); q2.delete();
      send(8'h01);
      send(8'h01);
      in_valid = 1'b0;
      tick();
      check("t3_err",    64'(err8),  64'd1);
      check("t3_rdy",    64'(rdy8),  64'd0);
      check("t3_crst",   64'(crst8), 64'd0);
      check("t3_err2",   64'(err2),  64'd1);
      tick();
      check("t3_nwr", 64'(q8.size()), 64'd0);
      pulse_start();
      check("t3_err_clr", 64'(err8), 64'd0);
      send(8'h00);
      send(8'h00);
      in_valid = 1'b0;
      tick();
      check("t3_done0", 64'(done8), 64'd1);
      check("t3_nwr0", 64'(q8.size()), 64'd0);

      // 4: full-depth image on the 2-bit-address instance
      pulse_start();
      q8.delete(); q2.delete();
      send(8'h00);
      send(8'h04);
      for (int w = 1; w <= 4; w++)
         for (int k = 0; k < 4; k++) send(8'(w * 17));
      in_valid = 1'b0;
      tick();
      tick();
      check("t4_done2", 64'(done2), 64'd1);
      check("t4_addr2", 64'(addr2), 64'd3);
      check("t4_nwr2",  64'(q2.size()), 64'd4);
      for (int w = 0; w < 4; w++)
         check_wr("t4_w", q2, w, 8'(w), {4{8'((w + 1) * 17)}});

      // 5: async reset in the middle of a 3-word load
      pulse_start();
      q8.delete(); q2.delete();
      send(8'h00); send(8'h03);
      send(8'h11); send(8'h22); send(8'h33); send(8'h44);
      check("t5_pre_we", 64'(we8), 64'd1);
      #2;
      RST = 1'b0;
      #1;
      check("t5_we",    64'(we8),    64'd0);
      check("t5_rdy",   64'(rdy8),   64'd0);
      check("t5_crst",  64'(crst8),  64'd0);
      check("t5_addr",  64'(addr8),  64'd0);
      check("t5_wdata", 64'(wdata8), 64'd0);
      in_valid = 1'b0;
      @(negedge CLK);
      RST = 1'b1;
      tick();
      check("t5_idle_rdy", 64'(rdy8), 64'd0);
      pulse_start();
      q8.delete(); q2.delete();
      send(8'h00); send(8'h01);
      send(8'hDE); send(8'hAD); send(8'hBE); send(8'hEF);
      in_valid = 1'b0;
      tick();
      tick();
      check("t5_done", 64'(done8), 64'd1);
      check("t5_nwr", 64'(q8.size()), 64'd1);
      check_wr("t5_w0", q8, 0, 8'd0, 32'hDEADBEEF);

      // 6: start ignored mid-stream, honoured in DONE
      pulse_start();
      check("t6_done_fall", 64'(done8), 64'd0);
      check("t6_crst_fall", 64'(crst8), 64'd0);
      check("t6_rdy_lenhi", 64'(rdy8),  64'd1);
      q8.delete(); q2.delete();
      for (int i = 0; i < 4; i++) send(img[i]);
      in_valid = 1'b0;
      pulse_start();
      check("t6_ign_rdy", 64'(rdy8), 64'd1);
      for (int i = 4; i < 10; i++) send(img[i]);
      in_valid = 1'b0;
      tick();
      tick();
      check("t6_done", 64'(done8), 64'd1);
      check("t6_addr_end", 64'(addr8), 64'd1);
      check("t6_nwr", 64'(q8.size()), 64'd2);
      check_wr("t6_w0", q8, 0, 8'd0, 32'h20010005);
      check_wr("t6_w1", q8, 1, 8'd1, 32'hAC010000);
      pulse_start();
      check("t6_reload_addr", 64'(addr8), 64'd0);
      check("t6_reload_done", 64'(done8), 64'd0);
      q8.delete(); q2.delete();
      send(8'h00); send(8'h01);
      send(8'hCA); send(8'hFE); send(8'hF0); send(8'h0D);
      in_valid = 1'b0;
      tick();
      tick();
      check("t6_done2", 64'(done8), 64'd1);
      check_wr("t6_rw0", q8, 0, 8'd0, 32'hCAFEF00D);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Byte-stream program loader that writes instruction memory; the processor only ever reads that memory.
- Accepts a valid/ready byte stream consisting of a 16-bit word-count header followed by big-endian 32-bit instruction words.
- Writes each assembled word to consecutive word addresses starting at 0, matching the processor's PC+1 word addressing.
- Holds the processor in reset until the full image is written, then releases it.

Parameters:
ADDR_WIDTH, 8, instruction memory word-address width; depth = 2**ADDR_WIDTH words
DATA_WIDTH, 32, instruction width; fixed at 32 (4 bytes per word)

Ports:
CLK  input  1  clock, rising edge
RST  input  1  reset, asynchronous, active-low
start  input  1  single-cycle pulse; begins a load from IDLE, DONE or ERR
in_data  input  8  stream byte
in_valid  input  1  in_data valid
in_ready  output  1  loader accepts a byte this cycle; a transfer occurs when in_valid&&in_ready
mem_we  output  1  instruction memory write enable, one cycle per word
mem_addr  output  ADDR_WIDTH  word address of the write
mem_wdata  output  32  word written
cpu_rst_n  output  1  processor reset, active-low; low until the load completes
done  output  1  high while in DONE
error  output  1  high while in ERR

Behaviour:
- Reset (RST=0, async): state=IDLE; in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_rst_n=0, done=0, error=0; internal count, byte index and shift register cleared.
- States: IDLE, LEN_HI, LEN_LO, DATA, WRITE, DONE, ERR.
- IDLE:
  - in_ready=0.
  - start -> LEN_HI; mem_addr cleared to 0.
- LEN_HI:
  - in_ready=1.
  - On a transfer, count[15:8]=in_data -> LEN_LO.
- LEN_LO:
  - in_ready=1.
  - On a transfer, count[7:0]=in_data.
  - Next state is evaluated on the full 16-bit count:
    - count==0 -> DONE.
    - count > 2**ADDR_WIDTH -> ERR.
    - Otherwise -> DATA, byte index=0.
- DATA:
  - in_ready=1.
  - Each transfer shifts the byte in, big-endian: the first byte becomes bits [31:24], the fourth becomes bits [7:0].
  - The fourth transfer -> WRITE.
  - Cycles with in_valid=0 are stalls with no state change; there is no timeout.
- WRITE (exactly one cycle):
  - in_ready=0, mem_we=1, mem_wdata=assembled word, mem_addr=current word address.
  - If this is the last word (words written == count), next state is DONE.
  - Otherwise mem_addr increments by 1, byte index returns to 0, and next state is DATA.
- DONE:
  - done=1, cpu_rst_n=1, in_ready=0.
  - start -> LEN_HI, with done=0 and cpu_rst_n=0 in the next cycle.
- ERR:
  - error=1, in_ready=0, cpu_rst_n=0.
  - No memory writes occur.
  - start -> LEN_HI.
- Registered outputs: mem_we, mem_addr, mem_wdata, done, error and cpu_rst_n are registered. in_ready is a pure decode of the current state.
- Latency: a transfer of the 4th byte at edge t gives mem_we=1 in cycle t..t+1. After the last word, done=1 and cpu_rst_n=1 from edge t+2.
- start handling: start is ignored in LEN_HI, LEN_LO, DATA and WRITE, so a load cannot be restarted mid-stream.
- Boundaries:
  - count == 2**ADDR_WIDTH is legal and fills the memory exactly. mem_addr never wraps because the last write is at the all-ones address.
  - Bytes offered while in_ready=0 are not consumed, and in_valid may stay high across the WRITE cycle.
- Reset mid-load: all outputs return to their reset values immediately. Partially written memory contents are not cleared; the memory is not owned by this block.
- mem_wdata and mem_addr hold their last values when mem_we=0.

Test Plan:
1. Reset, start, stream 00 02 | 20 01 00 05 | AC 01 00 00 with in_valid continuous -> mem_we pulses twice: addr 0 data 0x20010005, then addr 1 data 0xAC010000. done=1 and cpu_rst_n=1 two cycles after the last byte. in_ready=0 in each WRITE cycle.
2. Same 2-word image with in_valid toggling 1/0 every cycle -> identical writes and data. No byte is lost or duplicated, and in_ready stays high through the stalls.
3. With ADDR_WIDTH=8, header 01 01 (257 words) -> ERR: error=1, in_ready=0, no mem_we, cpu_rst_n=0. A following start plus header 00 00 -> DONE with no writes and done=1.
4. ADDR_WIDTH=2, header 00 04, four words 0x11111111..0x44444444 -> writes at addrs 0,1,2,3 in order, no wrap, then DONE.
5. Assert RST=0 after 6 bytes of a 3-word load -> outputs reset asynchronously (cpu_rst_n=0, mem_we=0, state IDLE). After release, start plus a full 1-word stream 00 01 DE AD BE EF -> addr 0 data 0xDEADBEEF, then DONE.
6. Pulse start while in DATA -> ignored, and the load completes normally. Pulse start in DONE -> done falls and cpu_rst_n goes low on the next edge, and a reload begins at addr 0.
